// File: rtl/spi_flash_word_arbiter.sv
// Round-robin arbiter that shares one byte-wide SPI flash read engine between two
// requesters and assembles four sequential byte reads into one little-endian word.
module spi_flash_word_arbiter (
  input  logic        clock_12MHz,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [23:0] req0_addr,
  output logic [31:0] req0_data,
  output logic        req0_done,
  input  logic        req1_valid,
  input  logic [23:0] req1_addr,
  output logic [31:0] req1_data,
  output logic        req1_done,
  output logic        spi_read_strobe,
  output logic [23:0] spi_read_addr,
  input  logic [7:0]  spi_read_data,
  input  logic        spi_read_busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic        last_grant;
  logic        port;
  logic [1:0]  byte_idx;
  logic [23:0] base;
  logic [31:0] word;
  logic        grant_any;
  logic        grant_port;
  logic        byte_ready;
  logic [31:0] word_merged;

  // 24-bit modulo byte address; wraps from 0xFFFFFF to 0x000000.
  function automatic logic [23:0] byte_addr(input logic [23:0] b, input logic [1:0] idx);
    return b + {22'd0, idx};
  endfunction

  function automatic logic [31:0] merge_byte(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] d);
    logic [31:0] r;
    r = w;
    r[8*idx +: 8] = d;
    return r;
  endfunction

  always_comb begin
    grant_any   = (req0_valid || req1_valid) && !spi_read_busy;
    // On a tie the port that did not win last time is granted.
    grant_port  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    byte_ready  = (state == WAIT) && !spi_read_busy;
    word_merged = merge_byte(word, byte_idx, spi_read_data);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = ARM;
      ARM:     state_nxt = WAIT;
      WAIT:    if (!spi_read_busy) state_nxt = (byte_idx == 2'd3) ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_12MHz) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      port       <= 1'b0;
      byte_idx   <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_any) begin
        port       <= grant_port;
        last_grant <= grant_port;
        byte_idx   <= 2'd0;
      end else if (byte_ready && byte_idx != 2'd3) begin
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

  // Base and partial word carry no reset: every fetch overwrites all four bytes.
  always_ff @(posedge clock_12MHz) begin
    if (state == IDLE && grant_any)
      base <= grant_port ? req1_addr : req0_addr;
    if (byte_ready)
      word <= word_merged;
  end

  // Returned words land on the transition into DONE so they are visible with done.
  always_ff @(posedge clock_12MHz) begin
    if (reset) begin
      req0_data <= 32'd0;
      req1_data <= 32'd0;
    end else if (byte_ready && byte_idx == 2'd3) begin
      if (port) req1_data <= word_merged;
      else      req0_data <= word_merged;
    end
  end

  always_comb begin
    spi_read_strobe = (state == ISSUE);
    spi_read_addr   = spi_read_strobe ? byte_addr(base, byte_idx) : 24'd0;
    req0_done       = (state == DONE) && !port;
    req1_done       = (state == DONE) && port;
  end

endmodule

// File: tb/tb_spi_flash_word_arbiter.sv
// Scoreboard bench for spi_flash_word_arbiter with a behavioural 81-cycle flash engine.
module tb_spi_flash_word_arbiter;

  logic        clock_12MHz = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [23:0] req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_done, req1_done;
  logic        spi_read_strobe;
  logic [23:0] spi_read_addr;
  logic [7:0]  spi_read_data = 8'd0;
  logic        spi_read_busy;

  spi_flash_word_arbiter dut (
    .clock_12MHz    (clock_12MHz),
    .reset          (reset),
    .req0_valid     (req0_valid),
    .req0_addr      (req0_addr),
    .req0_data      (req0_data),
    .req0_done      (req0_done),
    .req1_valid     (req1_valid),
    .req1_addr      (req1_addr),
    .req1_data      (req1_data),
    .req1_done      (req1_done),
    .spi_read_strobe(spi_read_strobe),
    .spi_read_addr  (spi_read_addr),
    .spi_read_data  (spi_read_data),
    .spi_read_busy  (spi_read_busy)
  );

  always #41 clock_12MHz = ~clock_12MHz;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  always @(posedge clock_12MHz) cycle <= cycle + 1;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h000000: return 8'hA0;
      24'h000001: return 8'hA1;
      24'h000002: return 8'hA2;
      24'h000003: return 8'hA3;
      24'h000010: return 8'hB0;
      24'h000011: return 8'hB1;
      24'h000012: return 8'hB2;
      24'h000013: return 8'hB3;
      24'h000020: return 8'hD0;
      24'h000021: return 8'hD1;
      24'h000022: return 8'hD2;
      24'h000023: return 8'hD3;
      24'h000030: return 8'hE0;
      24'h000031: return 8'hE1;
      24'h000032: return 8'hE2;
      24'h000033: return 8'hE3;
      24'h000100: return 8'h11;
      24'h000101: return 8'h22;
      24'h000102: return 8'h33;
      24'h000103: return 8'h44;
      24'hFFFFFE: return 8'hC0;
      24'hFFFFFF: return 8'hC1;
      default:    return 8'h00;
    endcase
  endfunction

  // Flash engine: no reset, busy for 81 cycles starting the cycle after the strobe.
  int busy_cnt = 0;
  always @(posedge clock_12MHz) begin
    if (spi_read_strobe) begin
      busy_cnt      <= 81;
      spi_read_data <= flash_byte(spi_read_addr);
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign spi_read_busy = (busy_cnt != 0);

  typedef struct {
    bit          port;
    logic [31:0] data;
  } exp_t;

  logic [23:0] strobe_q[$];
  exp_t        done_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic push_strobes(input logic [23:0] a0, a1, a2, a3);
    strobe_q.push_back(a0);
    strobe_q.push_back(a1);
    strobe_q.push_back(a2);
    strobe_q.push_back(a3);
  endtask

  task automatic push_done(input bit p, input logic [31:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    done_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, independent of the stimulus.
  int   scnt      = 0;
  int   first_cyc = 0;
  exp_t e_mon;
  always @(negedge clock_12MHz) begin
    if (reset) begin
      scnt = 0;
    end else begin
      if (spi_read_strobe) begin
        chk("strobe_while_busy", 32'(spi_read_busy), 32'd0);
        if (strobe_q.size() == 0) chk("unexpected_strobe", 32'(spi_read_addr), 32'hFFFF_FFFF);
        else chk("strobe_addr", 32'(spi_read_addr), 32'(strobe_q.pop_front()));
        if (scnt % 4 == 0) first_cyc = cycle;
        scnt++;
      end
      if (req0_done || req1_done) begin
        chk("single_done", 32'(req0_done && req1_done), 32'd0);
        if (done_q.size() == 0) begin
          chk("unexpected_done", {30'd0, req1_done, req0_done}, 32'd0);
        end else begin
          e_mon = done_q.pop_front();
          chk("done_port", 32'(req1_done), 32'(e_mon.port));
          chk("done_data", e_mon.port ? req1_data : req0_data, e_mon.data);
          chk("done_latency", 32'(cycle - first_cyc), 32'd332);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock_12MHz);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic wait_done(input bit p, input int maxc, input bit drop0, input bit drop1);
    int n;
    n = 0;
    while (!(p ? req1_done : req0_done) && n < maxc) begin
      step();
      n++;
    end
    if (n >= maxc) begin
      checks++;
      errors++;
      $display("FAIL timeout_done%0d: got no done after %0d cycles, required one", p, maxc);
    end
    if (drop0) req0_valid = 1'b0;
    if (drop1) req1_valid = 1'b0;
    step();
  endtask

  task automatic wait_strobes(input int count, input int maxc);
    int n, seen;
    n = 0;
    seen = 0;
    while (seen < count && n < maxc) begin
      step();
      if (spi_read_strobe) seen++;
      n++;
    end
    if (seen < count) begin
      checks++;
      errors++;
      $display("FAIL timeout_strobe: got %0d strobes, required %0d", seen, count);
    end
  endtask

  initial begin
    reset      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_addr  = 24'd0;
    req1_addr  = 24'd0;
    do_reset(3);

    chk("rst_strobe", 32'(spi_read_strobe), 32'd0);
    chk("rst_addr",   32'(spi_read_addr), 32'd0);
    chk("rst_done0",  32'(req0_done), 32'd0);
    chk("rst_done1",  32'(req1_done), 32'd0);
    chk("rst_data0",  req0_data, 32'd0);
    chk("rst_data1",  req1_data, 32'd0);

    // Single little-endian read on port 0
    push_strobes(24'h000100, 24'h000101, 24'h000102, 24'h000103);
    push_done(1'b0, 32'h44332211);
    req0_addr  = 24'h000100;
    req0_valid = 1'b1;
    wait_done(1'b0, 1000, 1'b1, 1'b0);
    chk("data1_untouched", req1_data, 32'd0);

    // Simultaneous requests from reset: port 0 first
    do_reset(2);
    push_strobes(24'h000000, 24'h000001, 24'h000002, 24'h000003);
    push_done(1'b0, 32'hA3A2A1A0);
    push_strobes(24'h000010, 24'h000011, 24'h000012, 24'h000013);
    push_done(1'b1, 32'hB3B2B1B0);
    req0_addr  = 24'h000000;
    req1_addr  = 24'h000010;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    wait_done(1'b0, 1000, 1'b1, 1'b0);
    wait_done(1'b1, 1000, 1'b0, 1'b1);
    chk("data0_retained", req0_data, 32'hA3A2A1A0);

    // Fairness: both held for four completions, order 0,1,0,1
    for (int i = 0; i < 2; i++) begin
      push_strobes(24'h000100, 24'h000101, 24'h000102, 24'h000103);
      push_done(1'b0, 32'h44332211);
      push_strobes(24'h000010, 24'h000011, 24'h000012, 24'h000013);
      push_done(1'b1, 32'hB3B2B1B0);
    end
    req0_addr  = 24'h000100;
    req1_addr  = 24'h000010;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    wait_done(1'b0, 1000, 1'b0, 1'b0);
    wait_done(1'b1, 1000, 1'b0, 1'b0);
    wait_done(1'b0, 1000, 1'b0, 1'b0);
    wait_done(1'b1, 1000, 1'b1, 1'b1);

    // Address wrap on port 1
    push_strobes(24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001);
    push_done(1'b1, 32'hA1A0C1C0);
    req1_addr  = 24'hFFFFFE;
    req1_valid = 1'b1;
    wait_done(1'b1, 1000, 1'b0, 1'b1);

    // Reset during the WAIT of byte 2; request stays high across reset
    push_strobes(24'h000020, 24'h000021, 24'h000022, 24'h000020);
    strobe_q.push_back(24'h000021);
    strobe_q.push_back(24'h000022);
    strobe_q.push_back(24'h000023);
    push_done(1'b0, 32'hD3D2D1D0);
    req0_addr  = 24'h000020;
    req0_valid = 1'b1;
    wait_strobes(3, 1000);
    repeat (10) step();
    do_reset(1);
    chk("midrst_data0", req0_data, 32'd0);
    chk("midrst_data1", req1_data, 32'd0);
    wait_done(1'b0, 1000, 1'b1, 1'b0);

    // Requester drops valid and changes address mid-fetch
    push_strobes(24'h000030, 24'h000031, 24'h000032, 24'h000033);
    push_done(1'b0, 32'hE3E2E1E0);
    req0_addr  = 24'h000030;
    req0_valid = 1'b1;
    wait_strobes(1, 100);
    repeat (5) step();
    req0_valid = 1'b0;
    req0_addr  = 24'h000100;
    wait_done(1'b0, 1000, 1'b0, 1'b0);
    repeat (400) step();

    chk("strobe_q_empty", 32'(strobe_q.size()), 32'd0);
    chk("done_q_empty",   32'(done_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
